// File: rtl/lfsr.sv
// -----------------------------------------------------------------------------
// lfsr
// 8-bit Galois LFSR with a serial LSB-first readout port.
//
// The state register is loaded from Seed while Reset is high. It advances one
// step on every clock with Enable high. With Enable low and OUT_Enable high,
// the current state is shifted out one bit per clock on OUT, with Valid
// marking each of the 8 bit-times.
//
// Ports
//   Clock      in   1  rising-edge clock
//   Reset      in   1  synchronous, active-high; loads Seed, clears outputs
//   Seed       in   8  initial state, sampled only while Reset is high
//   Enable     in   1  advance the LFSR one step this cycle
//   OUT_Enable in   1  request serial readout of the current state
//   OUT        out  1  serial data bit (registered)
//   Valid      out  1  OUT carries a state bit this cycle (registered)
// -----------------------------------------------------------------------------
module lfsr (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] Seed,
    input  logic       Enable,
    input  logic       OUT_Enable,
    output logic       OUT,
    output logic       Valid
);

    // Feedback mask applied when the bit shifted out of L[0] is 1. It is the
    // tap mask 8'b10101010 shifted right, with the feedback bit placed at L[7].
    localparam logic [7:0] FB_MASK = 8'hD5;

    // One frame carries this many bits.
    localparam logic [3:0] FRAME_BITS = 4'd8;

    // Single Galois step: shift right, fold the outgoing bit into the taps.
    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        logic [7:0] nxt;
        if (cur[0]) begin
            nxt = (cur >> 1) ^ FB_MASK;
        end else begin
            nxt = cur >> 1;
        end
        return nxt;
    endfunction

    // Rotate right by one; eight rotations restore the original state, so a
    // readout leaves L unchanged once the frame completes.
    function automatic logic [7:0] rotate_right(input logic [7:0] cur);
        return {cur[0], cur[7:1]};
    endfunction

    logic [7:0] l_q,     l_d;
    logic [3:0] cnt_q,   cnt_d;
    logic       out_q,   out_d;
    logic       valid_q, valid_d;

    // Next-state logic: Enable takes precedence over OUT_Enable.
    always_comb begin
        l_d     = l_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        valid_d = 1'b0;

        if (Enable) begin
            l_d   = lfsr_step(l_q);
            cnt_d = 4'd0;
        end else if (OUT_Enable) begin
            if (cnt_q < FRAME_BITS) begin
                out_d   = l_q[0];
                valid_d = 1'b1;
                l_d     = rotate_right(l_q);
                cnt_d   = cnt_q + 4'd1;
            end else begin
                // Frame already delivered: hold everything until Enable or
                // Reset clears the bit counter.
                cnt_d = cnt_q;
            end
        end else begin
            // Idle or paused mid-frame: the held counter lets the frame resume.
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous reset that aborts any frame in progress.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            l_q     <= Seed;
            cnt_q   <= 4'd0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            l_q     <= l_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign OUT   = out_q;
    assign Valid = valid_q;

endmodule

// File: tb/tb_lfsr.sv
// -----------------------------------------------------------------------------
// tb_lfsr
// Directed self-checking bench for lfsr. Expected states were worked out by
// hand from next = (L >> 1) ^ (L[0] ? 8'hD5 : 8'h00).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_lfsr;

    logic       Clock;
    logic       Reset;
    logic [7:0] Seed;
    logic       Enable;
    logic       OUT_Enable;
    logic       OUT;
    logic       Valid;

    int checks;
    int errors;

    lfsr dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Seed       (Seed),
        .Enable     (Enable),
        .OUT_Enable (OUT_Enable),
        .OUT        (OUT),
        .Valid      (Valid)
    );

    // Free-running clock, 10 time-unit period.
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Count one comparison and report it if it does not match.
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // One-cycle reset pulse loading seed; Seed is then scrambled to show it is
    // ignored once Reset is low.
    task automatic do_reset(input logic [7:0] seed);
        Seed       = seed;
        Reset      = 1'b1;
        Enable     = 1'b0;
        OUT_Enable = 1'b0;
        tick();
        chk("rst_valid", {7'd0, Valid}, 8'h00);
        chk("rst_out",   {7'd0, OUT},   8'h00);
        Reset = 1'b0;
        Seed  = seed ^ 8'hFF;
    endtask

    // Apply n enabled steps.
    task automatic step(input int n);
        Enable = 1'b1;
        repeat (n) tick();
        Enable = 1'b0;
    endtask

    // Full uninterrupted readout: Valid high for 8 cycles, bits reassembled
    // LSB-first, then Valid low with OUT holding the last bit.
    task automatic read_frame(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        got        = 8'h00;
        OUT_Enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("frame_valid", {7'd0, Valid}, 8'h01);
            got[i] = OUT;
        end
        tick();
        chk("frame_end_valid", {7'd0, Valid}, 8'h00);
        chk("frame_end_out",   {7'd0, OUT},   {7'd0, exp[7]});
        OUT_Enable = 1'b0;
        chk(tag, got, exp);
    endtask

    // Expect one serial bit with Valid high.
    task automatic expect_bit(input logic b);
        tick();
        chk("bit_valid", {7'd0, Valid}, 8'h01);
        chk("bit_out",   {7'd0, OUT},   {7'd0, b});
    endtask

    logic [7:0] seeds   [5] = '{8'h93, 8'h01, 8'hFF, 8'h5A, 8'h80};
    logic [7:0] after10 [5] = '{8'hB1, 8'hEA, 8'hAA, 8'hC3, 8'h8A};

    initial begin
        checks     = 0;
        errors     = 0;
        Reset      = 1'b1;
        Seed       = 8'h93;
        Enable     = 1'b0;
        OUT_Enable = 1'b0;

        // Reset load and plain readout of the seed.
        do_reset(8'h93);
        read_frame("seed_93", 8'h93);
        // Frame done: OUT_Enable still high, no more bits.
        OUT_Enable = 1'b1;
        repeat (3) tick();
        chk("done_valid", {7'd0, Valid}, 8'h00);
        chk("done_out",   {7'd0, OUT},   8'h01);
        OUT_Enable = 1'b0;

        // Single step, readout restores state, second step.
        do_reset(8'h93);
        step(1);
        chk("step_valid", {7'd0, Valid}, 8'h00);
        read_frame("step1_9c", 8'h9C);
        step(1);
        chk("step_out_hold", {7'd0, OUT}, 8'h01);
        read_frame("step2_4e", 8'h4E);

        // Ten steps from several seeds (0xFF and 0x5A sit on short cycles).
        for (int s = 0; s < 5; s++) begin
            do_reset(seeds[s]);
            step(10);
            read_frame("ten_steps", after10[s]);
        end

        // Priority: Enable wins over OUT_Enable, then frame starts at bit 0.
        do_reset(8'h93);
        Enable     = 1'b1;
        OUT_Enable = 1'b1;
        tick();
        chk("prio_valid", {7'd0, Valid}, 8'h00);
        chk("prio_out",   {7'd0, OUT},   8'h00);
        Enable = 1'b0;
        read_frame("prio_9c", 8'h9C);

        // Pause after 3 bits, then resume with the remaining 5.
        do_reset(8'h93);
        OUT_Enable = 1'b1;
        expect_bit(1'b1);
        expect_bit(1'b1);
        expect_bit(1'b0);
        OUT_Enable = 1'b0;
        tick();
        chk("pause_valid", {7'd0, Valid}, 8'h00);
        chk("pause_out",   {7'd0, OUT},   8'h00);
        tick();
        chk("pause_valid2", {7'd0, Valid}, 8'h00);
        OUT_Enable = 1'b1;
        expect_bit(1'b0);
        expect_bit(1'b1);
        expect_bit(1'b0);
        expect_bit(1'b0);
        expect_bit(1'b1);
        tick();
        chk("resume_end_valid", {7'd0, Valid}, 8'h00);
        OUT_Enable = 1'b0;

        // Reset mid-frame aborts the frame and loads the new seed.
        do_reset(8'h93);
        OUT_Enable = 1'b1;
        expect_bit(1'b1);
        expect_bit(1'b1);
        Seed  = 8'h3C;
        Reset = 1'b1;
        tick();
        chk("midrst_valid", {7'd0, Valid}, 8'h00);
        chk("midrst_out",   {7'd0, OUT},   8'h00);
        Reset = 1'b0;
        Seed  = 8'h00;
        read_frame("midrst_3c", 8'h3C);

        // Zero seed locks up.
        do_reset(8'h00);
        step(20);
        read_frame("lockup", 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
